boron_enc_core: RTL



---
 rtl/boron_enc_core.sv | 157 +++++++++++++++
 1 files changed

// File: rtl/boron_enc_core.sv
// Iterative BORON encryption core: one round per clock, 80/128-bit key,
// valid/ready streaming with output backpressure and optional CBC chaining.
module boron_enc_core #(
  parameter int KEY_W  = 80,
  parameter int ROUNDS = 25,
  parameter int RC_W   = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [KEY_W-1:0] key_in,
  input  logic             key_load,
  input  logic [63:0]      iv_in,
  input  logic             iv_load,
  input  logic             cbc_en,
  input  logic [63:0]      in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [63:0]      out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             busy
);

  if (!(KEY_W == 80 || KEY_W == 128)) begin : g_bad_key_w
    $error("boron_enc_core: KEY_W must be 80 or 128");
  end
  if ((2 ** RC_W) <= ROUNDS || ROUNDS < 1) begin : g_bad_rc_w
    $error("boron_enc_core: RC_W too narrow for ROUNDS");
  end

  typedef enum logic [1:0] {IDLE, ROUND, FINAL, HOLD} state_e;

  state_e           st_q, st_d;
  logic [63:0]      data_q, data_d;
  logic [KEY_W-1:0] key_q, key_d;
  logic [KEY_W-1:0] rk_q, rk_d;
  logic [63:0]      chain_q, chain_d;
  logic [RC_W-1:0]  cnt_q, cnt_d;
  logic             cbc_q, cbc_d;
  logic [63:0]      out_q, out_d;
  logic             ov_q, ov_d;

  function automatic logic [3:0] sbox4(input logic [3:0] x);
    case (x)
      4'h0: sbox4 = 4'hE;  4'h1: sbox4 = 4'h4;  4'h2: sbox4 = 4'hB;  4'h3: sbox4 = 4'h1;
      4'h4: sbox4 = 4'h7;  4'h5: sbox4 = 4'h9;  4'h6: sbox4 = 4'hC;  4'h7: sbox4 = 4'hA;
      4'h8: sbox4 = 4'hD;  4'h9: sbox4 = 4'h2;  4'hA: sbox4 = 4'h0;  4'hB: sbox4 = 4'hF;
      4'hC: sbox4 = 4'h8;  4'hD: sbox4 = 4'h5;  4'hE: sbox4 = 4'h3;  default: sbox4 = 4'h6;
    endcase
  endfunction

  // Output byte i takes input byte (3*i+5) mod 8; words then rotate by 1/4/7/9
  // and are chained with XOR from the low word upwards.
  function automatic logic [63:0] round_fn(input logic [63:0] s);
    logic [63:0] sb;
    logic [63:0] sh;
    logic [15:0] w0, w1, w2, w3;
    for (int i = 0; i < 16; i++) sb[4*i +: 4] = sbox4(s[4*i +: 4]);
    sh = {sb[23:16], sb[63:56], sb[39:32], sb[15:8],
          sb[55:48], sb[31:24], sb[7:0],   sb[47:40]};
    w0 = {sh[14:0],  sh[15]};
    w1 = {sh[27:16], sh[31:28]};
    w2 = {sh[40:32], sh[47:41]};
    w3 = {sh[54:48], sh[63:55]};
    w1 = w1 ^ w0;
    w2 = w2 ^ w1;
    w3 = w3 ^ w2;
    return {w3, w2, w1, w0};
  endfunction

  function automatic logic [KEY_W-1:0] key_sched(input logic [KEY_W-1:0] k,
                                                 input logic [RC_W-1:0]  rc);
    logic [KEY_W-1:0] r;
    logic [4:0]       rc5;
    rc5 = 5'(rc);
    r = {k[KEY_W-14:0], k[KEY_W-1:KEY_W-13]};
    r[3:0] = sbox4(r[3:0]);
    if (KEY_W == 128) r[7:4] = sbox4(r[7:4]);
    r[63:59] = r[63:59] ^ rc5;
    return r;
  endfunction

  assign in_ready  = (st_q == IDLE) && !key_load && !iv_load && reset;
  assign busy      = (st_q != IDLE);
  assign out_valid = ov_q;
  assign out_data  = out_q;

  always_comb begin
    st_d    = st_q;
    data_d  = data_q;
    key_d   = key_q;
    rk_d    = rk_q;
    chain_d = chain_q;
    cnt_d   = cnt_q;
    cbc_d   = cbc_q;
    out_d   = out_q;
    ov_d    = ov_q;
    case (st_q)
      IDLE: begin
        if (key_load) key_d = key_in;
        if (iv_load) chain_d = iv_in;
        if (in_valid && in_ready) begin
          data_d = cbc_en ? (in_data ^ chain_q) : in_data;
          rk_d   = key_q;
          cnt_d  = RC_W'(1);
          cbc_d  = cbc_en;
          st_d   = ROUND;
        end
      end
      ROUND: begin
        data_d = round_fn(data_q ^ rk_q[63:0]);
        rk_d   = key_sched(rk_q, cnt_q);
        // Hold the counter at ROUNDS so it can never wrap.
        if (cnt_q == RC_W'(ROUNDS)) st_d = FINAL;
        else cnt_d = cnt_q + RC_W'(1);
      end
      FINAL: begin
        out_d = data_q ^ rk_q[63:0];
        ov_d  = 1'b1;
        if (cbc_q) chain_d = data_q ^ rk_q[63:0];
        st_d  = HOLD;
      end
      HOLD: begin
        if (ov_q && out_ready) begin
          ov_d = 1'b0;
          st_d = IDLE;
        end
      end
      default: st_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      st_q    <= IDLE;
      data_q  <= '0;
      key_q   <= '0;
      rk_q    <= '0;
      chain_q <= '0;
      cnt_q   <= '0;
      cbc_q   <= 1'b0;
      out_q   <= '0;
      ov_q    <= 1'b0;
    end else begin
      st_q    <= st_d;
      data_q  <= data_d;
      key_q   <= key_d;
      rk_q    <= rk_d;
      chain_q <= chain_d;
      cnt_q   <= cnt_d;
      cbc_q   <= cbc_d;
      out_q   <= out_d;
      ov_q    <= ov_d;
    end
  end

endmodule
